// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the RV32I ALU-op decode stage.
//   alu_op_e  - 4-bit ALUop code consumed by the ALU ({funct7[5], funct3})
//   OPC_*     - major opcodes handled by the decoder
//   dec_t     - one decoded instruction entry, as held in the pipeline register
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        alu_op_e     alu_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        alub_src;
        logic        reg_we;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/alu_dec_comb.sv
// alu_dec_comb: purely combinational RV32I OP / OP-IMM / LUI decoder.
// Ports:
//   instr - raw 32-bit instruction word
//   dec   - decoded entry (ALUop, register indices, immediate, selects, illegal)
// Unsupported opcodes and bad funct7 values give illegal=1 with every control
// field cleared; register index fields are still passed through.
module alu_dec_comb
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign shamt  = instr[24:20];

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_ADD;
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.rd     = instr[11:7];

        case (opcode)
            OPC_OP: begin
                // funct7=0100000 is only meaningful for SUB and SRA
                if (funct7 == F7_ZERO ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec.alu_op = alu_op_e'({funct7[5], funct3});
                    dec.reg_we = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                case (funct3)
                    3'b001: begin
                        if (funct7 == F7_ZERO) begin
                            dec.alu_op   = ALU_SLL;
                            dec.imm      = {27'b0, shamt};
                            dec.alub_src = 1'b1;
                            dec.reg_we   = 1'b1;
                        end else begin
                            dec.illegal = 1'b1;
                        end
                    end
                    3'b101: begin
                        if (funct7 == F7_ZERO || funct7 == F7_ALT) begin
                            dec.alu_op   = funct7[5] ? ALU_SRA : ALU_SRL;
                            dec.imm      = {27'b0, shamt};
                            dec.alub_src = 1'b1;
                            dec.reg_we   = 1'b1;
                        end else begin
                            dec.illegal = 1'b1;
                        end
                    end
                    default: begin
                        // no SUB form for immediates: bit 3 is always 0 here
                        dec.alu_op   = alu_op_e'({1'b0, funct3});
                        dec.imm      = {{20{instr[31]}}, instr[31:20]};
                        dec.alub_src = 1'b1;
                        dec.reg_we   = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                // LUI executes as x0 + imm, so rs1 is forced to x0
                dec.rs1      = 5'd0;
                dec.imm      = {instr[31:12], 12'b0};
                dec.alub_src = 1'b1;
                dec.reg_we   = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase

        if (dec.illegal) begin
            dec.alu_op   = ALU_ADD;
            dec.imm      = '0;
            dec.alub_src = 1'b0;
            dec.reg_we   = 1'b0;
        end
    end

endmodule

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: registered decode stage between fetch and the RF/ALU datapath.
// One-entry pipeline register with valid/ready on both sides, latency 1,
// full throughput.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   in_valid/in_ready  - upstream handshake, instr accepted on in_valid & in_ready
//   instr              - raw instruction word
//   out_valid/out_ready- downstream handshake
//   alu_op, rs1, rs2, rd, imm, alub_src, reg_we, illegal - decoded entry
//   illegal_cnt        - saturating count of accepted illegal instructions
// Configuration: define ALU_DEC_ILLCNT_EN to build the illegal-instruction
// counter; without it illegal_cnt is tied to 0.
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_op,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [31:0]      imm,
    output logic             alub_src,
    output logic             reg_we,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    dec_t dec_in;
    dec_t dec_q, dec_d;
    logic out_valid_q, out_valid_d;
    logic accept;

    alu_dec_comb u_dec (
        .instr (instr),
        .dec   (dec_in)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        dec_d       = dec_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            dec_d       = dec_in;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            // drained with nothing behind it: data fields keep their last value
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            dec_q       <= dec_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_op    = dec_q.alu_op;
    assign rs1       = dec_q.rs1;
    assign rs2       = dec_q.rs2;
    assign rd        = dec_q.rd;
    assign imm       = dec_q.imm;
    assign alub_src  = dec_q.alub_src;
    assign reg_we    = dec_q.reg_we;
    assign illegal   = dec_q.illegal;

`ifdef ALU_DEC_ILLCNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && dec_in.illegal && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign illegal_cnt = cnt_q;
`else
    assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_op_decoder.sv
module tb_alu_op_decoder;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       alu_op;
    logic [4:0]       rs1, rs2, rd;
    logic [31:0]      imm;
    logic             alub_src;
    logic             reg_we;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    int n_vec;
    int n_err;
    int exp_cnt;

    alu_op_decoder #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_op      (alu_op),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .imm         (imm),
        .alub_src    (alub_src),
        .reg_we      (reg_we),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counter model: counts accepted illegals, saturating at 2**CNT_W-1 when built.
    task automatic bump_cnt();
`ifdef ALU_DEC_ILLCNT_EN
        if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = 32'h0;
        step(); step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_hold_valid got %0b exp 0", out_valid); end
        rst = 1'b0;
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        n_vec++; if (alu_op !== 4'h0) begin n_err++; $display("FAIL reset_aluop got %h exp 0", alu_op); end
        n_vec++; if (imm !== 32'h0) begin n_err++; $display("FAIL reset_imm got %h exp 0", imm); end
        n_vec++; if (illegal_cnt !== 2'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", illegal_cnt); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        n_vec++; if (reg_we !== 1'b0 || illegal !== 1'b0) begin n_err++; $display("FAIL reset_flags got we=%0b ill=%0b exp 0/0", reg_we, illegal); end
    endtask

    task automatic test_sub();
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h40208133;
        step();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sub_valid got %0b exp 1", out_valid); end
        n_vec++; if (alu_op !== 4'b1000) begin n_err++; $display("FAIL sub_aluop got %b exp 1000", alu_op); end
        n_vec++; if (rs1 !== 5'd1 || rs2 !== 5'd2 || rd !== 5'd2) begin n_err++; $display("FAIL sub_regs got %0d/%0d/%0d exp 1/2/2", rs1, rs2, rd); end
        n_vec++; if (alub_src !== 1'b0 || reg_we !== 1'b1 || illegal !== 1'b0) begin n_err++; $display("FAIL sub_ctl got src=%0b we=%0b ill=%0b exp 0/1/0", alub_src, reg_we, illegal); end
        n_vec++; if (imm !== 32'h0) begin n_err++; $display("FAIL sub_imm got %h exp 0", imm); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h40335293;
        step();
        instr = 32'hFFF00093;
        n_vec++; if (alu_op !== 4'b1101) begin n_err++; $display("FAIL srai_aluop got %b exp 1101", alu_op); end
        n_vec++; if (rs1 !== 5'd6 || rd !== 5'd5) begin n_err++; $display("FAIL srai_regs got %0d/%0d exp 6/5", rs1, rd); end
        n_vec++; if (imm !== 32'd3 || alub_src !== 1'b1) begin n_err++; $display("FAIL srai_imm got %h src=%0b exp 3/1", imm, alub_src); end
        step();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid got %0b exp 1", out_valid); end
        n_vec++; if (alu_op !== 4'b0000 || imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL addi_fields got %b/%h exp 0000/ffffffff", alu_op, imm); end
        n_vec++; if (rd !== 5'd1 || rs1 !== 5'd0) begin n_err++; $display("FAIL addi_regs got rd=%0d rs1=%0d exp 1/0", rd, rs1); end
    endtask

    task automatic test_stall();
        // addi entry is currently held; present add x3,x1,x2 while stalled
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3;
        #1;
        for (int c = 0; c < 2; c++) begin
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready cyc %0d got %0b exp 0", c, in_ready); end
            step();
            n_vec++; if (out_valid !== 1'b1 || imm !== 32'hFFFFFFFF || rd !== 5'd1) begin n_err++; $display("FAIL stall_hold cyc %0d got v=%0b imm=%h rd=%0d exp 1/ffffffff/1", c, out_valid, imm, rd); end
        end
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready got %0b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || rd !== 5'd3 || rs2 !== 5'd2 || imm !== 32'h0 || alub_src !== 1'b0) begin
            n_err++; $display("FAIL release_capture got v=%0b rd=%0d rs2=%0d imm=%h src=%0b exp 1/3/2/0/0", out_valid, rd, rs2, imm, alub_src);
        end
        step();
        n_vec++; if (out_valid !== 1'b0 || rd !== 5'd3) begin n_err++; $display("FAIL drain got v=%0b rd=%0d exp 0/3", out_valid, rd); end
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  op;
        logic [4:0]  r1;
        logic [4:0]  rdst;
        logic [31:0] im;
        logic        src;
    } vec_t;

    task automatic test_decode_mix();
        vec_t v [5];
        v[0] = '{32'h123452B7, 4'b0000, 5'd0, 5'd5, 32'h12345000, 1'b1}; // lui x5,0x12345
        v[1] = '{32'h80044393, 4'b0100, 5'd8, 5'd7, 32'hFFFFF800, 1'b1}; // xori x7,x8,-2048
        v[2] = '{32'h4020D133, 4'b1101, 5'd1, 5'd2, 32'h0,        1'b0}; // sra x2,x1,x2
        v[3] = '{32'h0020B133, 4'b0011, 5'd1, 5'd2, 32'h0,        1'b0}; // sltu x2,x1,x2
        v[4] = '{32'h00435293, 4'b0101, 5'd6, 5'd5, 32'h4,        1'b1}; // srli x5,x6,4
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instr = v[i].ins;
            step();
            n_vec++;
            if (out_valid !== 1'b1 || alu_op !== v[i].op || rs1 !== v[i].r1 || rd !== v[i].rdst ||
                imm !== v[i].im || alub_src !== v[i].src || reg_we !== 1'b1 || illegal !== 1'b0) begin
                n_err++;
                $display("FAIL mix[%0d] got v=%0b op=%b rs1=%0d rd=%0d imm=%h src=%0b we=%0b ill=%0b exp 1/%b/%0d/%0d/%h/%0b/1/0",
                         i, out_valid, alu_op, rs1, rd, imm, alub_src, reg_we, illegal,
                         v[i].op, v[i].r1, v[i].rdst, v[i].im, v[i].src);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_illegal();
        logic [31:0] ins  [5];
        logic [4:0]  erd  [5];
        ins[0] = 32'h00000000; erd[0] = 5'd0;  // opcode 0000000
        ins[1] = 32'h02208133; erd[1] = 5'd2;  // OP with funct7 0000001
        ins[2] = 32'h40209133; erd[2] = 5'd2;  // sll with funct7 0100000
        ins[3] = 32'h40031293; erd[3] = 5'd5;  // slli with funct7 0100000
        ins[4] = 32'h0000007F; erd[4] = 5'd0;  // unknown opcode
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instr = ins[i];
            step();
            bump_cnt();
            n_vec++;
            if (out_valid !== 1'b1 || illegal !== 1'b1 || reg_we !== 1'b0 || alu_op !== 4'b0000 ||
                imm !== 32'h0 || alub_src !== 1'b0 || rd !== erd[i]) begin
                n_err++;
                $display("FAIL illegal[%0d] got v=%0b ill=%0b we=%0b op=%b imm=%h src=%0b rd=%0d exp 1/1/0/0000/0/0/%0d",
                         i, out_valid, illegal, reg_we, alu_op, imm, alub_src, rd, erd[i]);
            end
            n_vec++; if (illegal_cnt !== exp_cnt[CNT_W-1:0]) begin n_err++; $display("FAIL illcnt[%0d] got %0d exp %0d", i, illegal_cnt, exp_cnt); end
        end
        n_vec++; if (rs1 !== 5'd0 || rs2 !== 5'd0) begin n_err++; $display("FAIL illegal_idx got %0d/%0d exp 0/0", rs1, rs2); end
        // a legal instruction must not move the counter
        instr = 32'h002081B3;
        step();
        in_valid = 1'b0;
        n_vec++; if (illegal !== 1'b0 || illegal_cnt !== exp_cnt[CNT_W-1:0]) begin n_err++; $display("FAIL legal_after_ill got ill=%0b cnt=%0d exp 0/%0d", illegal, illegal_cnt, exp_cnt); end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h02208133;
        step();
        bump_cnt();
        instr = 32'h40208133;
        step();
        n_vec++; if (out_valid !== 1'b1 || illegal !== 1'b1) begin n_err++; $display("FAIL pre_rst_hold got v=%0b ill=%0b exp 1/1", out_valid, illegal); end
        rst = 1'b1;
        exp_cnt = 0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid got %0b exp 0", out_valid); end
        n_vec++; if (illegal_cnt !== 2'd0 || rd !== 5'd0 || illegal !== 1'b0) begin n_err++; $display("FAIL rst_async_data got cnt=%0d rd=%0d ill=%0b exp 0/0/0", illegal_cnt, rd, illegal); end
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        n_vec++; if (out_valid !== 1'b0 || illegal_cnt !== 2'd0) begin n_err++; $display("FAIL post_rst got v=%0b cnt=%0d exp 0/0", out_valid, illegal_cnt); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_cnt = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = 32'h0;
        test_reset();
        test_sub();
        test_back_to_back();
        test_stall();
        test_decode_mix();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
